// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - CPU/loader data-memory arbiter with loader burst lock
//
// Arbitrates one single-port data memory between a processor and a loader.
// Grants are combinational. The winning access is registered onto mem_*
// the following cycle, and read data comes back one cycle after the strobe.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata          processor request (held until cpu_gnt)
//   cpu_gnt, cpu_rdata, cpu_rvalid processor grant and read return
//   ld_req/we/addr/wdata, ld_lock  loader request and burst-priority request
//   ld_gnt, ld_rdata, ld_rvalid    loader grant and read return
//   mem_en/we/addr/wdata           registered memory access
//   mem_rdata                      memory read data, valid cycle after strobe
//   busy                           memory port committed (strobe or return)
module dm_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 12,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  input  logic              ld_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {RR = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] burst_cnt;
  logic             last_ld;   // 1: loader won the most recent RR grant
  logic             owner_ld;  // 1: access currently on mem_* belongs to the loader
  logic             at_max;
  logic             cpu_win;
  logic             ld_win;

  assign at_max = (burst_cnt == CNT_W'(MAX_BURST));

  always_comb begin
    cpu_win = 1'b0;
    ld_win  = 1'b0;
    if (state == RR) begin
      if (cpu_req && ld_req) begin
        cpu_win = last_ld;
        ld_win  = !last_ld;
      end else begin
        cpu_win = cpu_req;
        ld_win  = ld_req;
      end
    end else begin
      // A saturated burst lets a waiting CPU through exactly once.
      if (ld_req && !(cpu_req && at_max)) ld_win = 1'b1;
      else                                cpu_win = cpu_req;
    end
  end

  // No grant may be issued while the block is held in reset.
  assign cpu_gnt = cpu_win & rst_n;
  assign ld_gnt  = ld_win & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RR;
      burst_cnt  <= '0;
      last_ld    <= 1'b1;
      owner_ld   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rvalid <= 1'b0;
      ld_rvalid  <= 1'b0;
    end else begin
      mem_en <= cpu_gnt | ld_gnt;
      if (ld_gnt) begin
        mem_we    <= ld_we;
        mem_addr  <= ld_addr;
        mem_wdata <= ld_wdata;
        owner_ld  <= 1'b1;
      end else if (cpu_gnt) begin
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        owner_ld  <= 1'b0;
      end

      // Read data arrives the cycle after the strobe; flag it for its owner.
      cpu_rvalid <= mem_en & ~mem_we & ~owner_ld;
      ld_rvalid  <= mem_en & ~mem_we & owner_ld;

      case (state)
        RR: begin
          if (ld_gnt) begin
            last_ld <= 1'b1;
            if (ld_lock) begin
              state     <= LOCKED;
              burst_cnt <= CNT_W'(1);
            end
          end else if (cpu_gnt) begin
            last_ld <= 1'b0;
          end
        end
        LOCKED: begin
          if (!ld_lock) begin
            // Leaving the lock hands the next contention to the CPU.
            state     <= RR;
            burst_cnt <= '0;
            last_ld   <= 1'b1;
          end else if (ld_gnt) begin
            if (!at_max) burst_cnt <= burst_cnt + CNT_W'(1);
          end else if (cpu_gnt && ld_req) begin
            burst_cnt <= '0;
          end
        end
        default: state <= RR;
      endcase
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;
  assign ld_rdata  = ld_rvalid ? mem_rdata : '0;
  assign busy      = mem_en | cpu_rvalid | ld_rvalid;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter
module tb_dm_arbiter;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ld_req, ld_we, ld_gnt, ld_rvalid, ld_lock;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata, ld_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid), .ld_lock(ld_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Synchronous single-port memory, preloaded with a known pattern.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i * 7);
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Reference model: who may win, what each grant does to memory, when data returns.
  bit  m_locked, m_last_ld;
  int  m_streak, cyc;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  typedef struct { bit v; bit we; logic [AW-1:0] a; logic [DW-1:0] d; bit is_ld; } acc_t;
  typedef struct { int due; bit is_ld; logic [DW-1:0] d; } ret_t;
  acc_t m_acc;
  ret_t rq[$];

  task automatic model_reset();
    m_locked = 1'b0; m_last_ld = 1'b1; m_streak = 0; cyc = 0;
    m_acc = '{default: '0};
    rq.delete();
  endtask

  // 0 = nobody, 1 = CPU, 2 = loader
  function automatic int expected_winner();
    if (!cpu_req && !ld_req) return 0;
    if (!m_locked) begin
      if (cpu_req && ld_req) return m_last_ld ? 1 : 2;
      return cpu_req ? 1 : 2;
    end
    if (ld_req && !(cpu_req && m_streak >= MB)) return 2;
    return 1;
  endfunction

  task automatic model_advance(input int w);
    acc_t nxt;
    nxt = '{default: '0};
    if (w == 1) nxt = '{1'b1, cpu_we, cpu_addr, cpu_wdata, 1'b0};
    if (w == 2) nxt = '{1'b1, ld_we, ld_addr, ld_wdata, 1'b1};
    if (nxt.v && !nxt.we) rq.push_back('{cyc + 2, nxt.is_ld, ref_mem[nxt.a]});
    if (nxt.v && nxt.we)  ref_mem[nxt.a] = nxt.d;
    if (m_locked && !ld_lock) begin
      m_locked = 1'b0; m_streak = 0; m_last_ld = 1'b1;
    end else if (m_locked) begin
      if (w == 2 && m_streak < MB) m_streak++;
      else if (w == 1 && ld_req)   m_streak = 0;
    end else begin
      if (w == 1) m_last_ld = 1'b0;
      if (w == 2) begin
        m_last_ld = 1'b1;
        if (ld_lock) begin m_locked = 1'b1; m_streak = 1; end
      end
    end
    m_acc = nxt;
    cyc++;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; ld_lock = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0; idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; cpu_req = 1; ld_req = 1; ld_lock = 1; cpu_addr = 12'h123; #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL reset_cpu_gnt: got %0b want 0", cpu_gnt); end
      n_cmp++; if (ld_gnt !== 1'b0) begin n_err++; $display("FAIL reset_ld_gnt: got %0b want 0", ld_gnt); end
      n_cmp++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin n_err++; $display("FAIL reset_mem: got en=%0b we=%0b a=%0h d=%0h want all 0", mem_en, mem_we, mem_addr, mem_wdata); end
      n_cmp++; if ({cpu_rvalid, ld_rvalid, cpu_rdata, ld_rdata, busy} !== '0) begin n_err++; $display("FAIL reset_ret: got crv=%0b lrv=%0b crd=%0h lrd=%0h busy=%0b want all 0", cpu_rvalid, ld_rvalid, cpu_rdata, ld_rdata, busy); end
      @(negedge clk); #1;
    end
    rst_n = 1; #1;
    n_cmp++; if ({cpu_gnt, ld_gnt} !== 2'b10) begin n_err++; $display("FAIL reset_first_gnt: got cpu=%0b ld=%0b want cpu=1 ld=0", cpu_gnt, ld_gnt); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (mem_en !== 1'b1 || mem_addr !== 12'h123) begin n_err++; $display("FAIL reset_first_access: got en=%0b a=%0h want en=1 a=123", mem_en, mem_addr); end
  endtask

  task automatic test_cpu_write_read();
    do_reset();
    @(negedge clk); cpu_req = 1; cpu_we = 1; cpu_addr = 12'h005; cpu_wdata = 12'hABC; #1;
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL wr_gnt: got %0b want 1", cpu_gnt); end
    @(negedge clk); cpu_we = 0; cpu_wdata = '0; #1;
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rd_gnt: got %0b want 1", cpu_gnt); end
    n_cmp++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'h005, 12'hABC}) begin n_err++; $display("FAIL wr_strobe: got en=%0b we=%0b a=%0h d=%0h want 1 1 005 abc", mem_en, mem_we, mem_addr, mem_wdata); end
    @(negedge clk); cpu_req = 0; #1;
    n_cmp++; if ({mem_en, mem_we, mem_addr, busy, cpu_rvalid} !== {1'b1, 1'b0, 12'h005, 1'b1, 1'b0}) begin n_err++; $display("FAIL rd_strobe: got en=%0b we=%0b a=%0h busy=%0b rv=%0b want 1 0 005 1 0", mem_en, mem_we, mem_addr, busy, cpu_rvalid); end
    @(negedge clk); #1;
    n_cmp++; if ({cpu_rvalid, cpu_rdata, ld_rvalid, mem_en} !== {1'b1, 12'hABC, 1'b0, 1'b0}) begin n_err++; $display("FAIL rd_return: got rv=%0b rd=%0h ldrv=%0b en=%0b want 1 abc 0 0", cpu_rvalid, cpu_rdata, ld_rvalid, mem_en); end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); cpu_req = 1; ld_req = 1; ld_lock = 0; #1;
      n_cmp++; if ({cpu_gnt, ld_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL contention[%0d]: got cpu=%0b ld=%0b want %s", i, cpu_gnt, ld_gnt, (i % 2 == 0) ? "cpu" : "ld"); end
    end
  endtask

  task automatic test_locked_burst();
    do_reset();
    for (int i = 0; i < 28; i++) begin
      logic want_cpu;
      @(negedge clk); cpu_req = 1; ld_req = 1; ld_lock = 1; #1;
      want_cpu = (i == 0) || ((i - 1) % (MB + 1) == MB);
      n_cmp++; if ({cpu_gnt, ld_gnt} !== (want_cpu ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL burst[%0d]: got cpu=%0b ld=%0b want %s", i, cpu_gnt, ld_gnt, want_cpu ? "cpu" : "ld"); end
    end
  endtask

  task automatic test_lock_release();
    logic [1:0] want [0:7];
    want = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); cpu_req = 1; ld_req = 1; ld_lock = (i < 4); #1;
      n_cmp++; if ({cpu_gnt, ld_gnt} !== want[i]) begin n_err++; $display("FAIL release[%0d]: got cpu=%0b ld=%0b want %b", i, cpu_gnt, ld_gnt, want[i]); end
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    @(negedge clk); ld_req = 1; ld_we = 0; ld_addr = 12'h007; #1;
    n_cmp++; if (ld_gnt !== 1'b1) begin n_err++; $display("FAIL midrd_gnt: got %0b want 1", ld_gnt); end
    @(negedge clk); rst_n = 0; ld_req = 0; cpu_req = 1; #1;
    n_cmp++; if ({mem_en, busy, cpu_gnt, ld_gnt} !== 4'b0) begin n_err++; $display("FAIL midrd_async: got en=%0b busy=%0b cg=%0b lg=%0b want 0", mem_en, busy, cpu_gnt, ld_gnt); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++; if ({ld_rvalid, cpu_rvalid, mem_en, mem_addr, ld_rdata, busy, cpu_gnt} !== '0) begin n_err++; $display("FAIL midrd_hold[%0d]: got lrv=%0b en=%0b a=%0h lrd=%0h busy=%0b cg=%0b want 0", k, ld_rvalid, mem_en, mem_addr, ld_rdata, busy, cpu_gnt); end
    end
    @(negedge clk); rst_n = 1; cpu_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (ld_rvalid !== 1'b0) begin n_err++; $display("FAIL midrd_after[%0d]: got ld_rvalid=%0b want 0", k, ld_rvalid); end
    end
  endtask

  task automatic test_idle();
    do_reset();
    @(negedge clk); cpu_req = 1; cpu_addr = 12'h020;
    @(negedge clk); cpu_req = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      n_cmp++; if ({mem_en, busy, cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid} !== 6'b0) begin n_err++; $display("FAIL idle[%0d]: got en=%0b busy=%0b cg=%0b lg=%0b crv=%0b lrv=%0b want 0", k, mem_en, busy, cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid); end
    end
    // CPU won last before the idle gap, so the loader must win now.
    @(negedge clk); cpu_req = 1; ld_req = 1; #1;
    n_cmp++; if ({cpu_gnt, ld_gnt} !== 2'b01) begin n_err++; $display("FAIL idle_held: got cpu=%0b ld=%0b want ld", cpu_gnt, ld_gnt); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_random();
    int w, last_w;
    bit ev, ev_ld;
    logic [DW-1:0] ev_d;
    do_reset();
    model_reset();
    last_w = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (last_w == 1) cpu_req = 0;
      if (last_w == 2) ld_req = 0;
      if (!cpu_req && $urandom_range(3) != 0) begin
        cpu_req = 1; cpu_we = 1'($urandom_range(1));
        cpu_addr = AW'(16 + $urandom_range(15)); cpu_wdata = DW'($urandom);
      end
      if (!ld_req && $urandom_range(3) != 0) begin
        ld_req = 1; ld_we = 1'($urandom_range(1));
        ld_addr = AW'(16 + $urandom_range(15)); ld_wdata = DW'($urandom);
      end
      if ($urandom_range(15) == 0) ld_lock = ~ld_lock;
      #1;
      w = expected_winner();
      n_cmp++; if ({cpu_gnt, ld_gnt} !== {w == 1, w == 2}) begin n_err++; $display("FAIL rnd_gnt@%0d: got cpu=%0b ld=%0b want winner %0d", c, cpu_gnt, ld_gnt, w); end
      n_cmp++; if (mem_en !== m_acc.v) begin n_err++; $display("FAIL rnd_mem_en@%0d: got %0b want %0b", c, mem_en, m_acc.v); end
      if (m_acc.v) begin
        n_cmp++; if (mem_we !== m_acc.we || mem_addr !== m_acc.a || (m_acc.we && mem_wdata !== m_acc.d)) begin n_err++; $display("FAIL rnd_mem@%0d: got we=%0b a=%0h d=%0h want we=%0b a=%0h d=%0h", c, mem_we, mem_addr, mem_wdata, m_acc.we, m_acc.a, m_acc.d); end
      end
      ev = 1'b0; ev_ld = 1'b0; ev_d = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        ev = 1'b1; ev_ld = rq[0].is_ld; ev_d = rq[0].d;
        void'(rq.pop_front());
      end
      n_cmp++; if ({cpu_rvalid, ld_rvalid} !== {ev && !ev_ld, ev && ev_ld}) begin n_err++; $display("FAIL rnd_rvalid@%0d: got cpu=%0b ld=%0b want cpu=%0b ld=%0b", c, cpu_rvalid, ld_rvalid, ev && !ev_ld, ev && ev_ld); end
      if (ev) begin
        n_cmp++; if ((ev_ld ? ld_rdata : cpu_rdata) !== ev_d) begin n_err++; $display("FAIL rnd_rdata@%0d: got %0h want %0h", c, ev_ld ? ld_rdata : cpu_rdata, ev_d); end
      end
      model_advance(w);
      last_w = w;
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = DW'(i * 7);
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_cpu_write_read();
    test_contention();
    test_locked_burst();
    test_lock_release();
    test_reset_mid_read();
    test_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
